// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [STRB_W-1:0] STRB_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_WR  = 2'd0,
        OP_DRD = 2'd1,
        OP_IRD = 2'd2
    } op_t;

    // Store first, then load, then fetch: a load after a store to the same
    // address in one capture sees the stored data.
    function automatic op_t pick_op(input logic wr, input logic drd);
        if (wr) begin
            return OP_WR;
        end
        if (drd) begin
            return OP_DRD;
        end
        return OP_IRD;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/load/store ports and the shared downstream request/response port.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              INST_RDEN;
    logic [ADDR_W-1:0] INST_RIADDR;
    logic [ADDR_W-1:0] INST_ROADDR;
    logic              INST_RVALID;
    logic [DATA_W-1:0] INST_RDATA;

    logic              DATA_RDEN;
    logic [ADDR_W-1:0] DATA_RIADDR;
    logic [ADDR_W-1:0] DATA_ROADDR;
    logic              DATA_RVALID;
    logic [DATA_W-1:0] DATA_RDATA;
    logic              DATA_WREN;
    logic [STRB_W-1:0] DATA_WSTRB;
    logic [ADDR_W-1:0] DATA_WADDR;
    logic [DATA_W-1:0] DATA_WDATA;

    logic              MEM_WAIT;
    logic              BUS_ERR;

    logic              M_REQ;
    logic              M_WE;
    logic [ADDR_W-1:0] M_ADDR;
    logic [STRB_W-1:0] M_WSTRB;
    logic [DATA_W-1:0] M_WDATA;
    logic              M_READY;
    logic              M_RVALID;
    logic [DATA_W-1:0] M_RDATA;

    modport master (
        input  INST_RDEN, INST_RIADDR,
        output INST_ROADDR, INST_RVALID, INST_RDATA,
        input  DATA_RDEN, DATA_RIADDR, DATA_WREN, DATA_WSTRB, DATA_WADDR, DATA_WDATA,
        output DATA_ROADDR, DATA_RVALID, DATA_RDATA,
        output MEM_WAIT, BUS_ERR,
        output M_REQ, M_WE, M_ADDR, M_WSTRB, M_WDATA,
        input  M_READY, M_RVALID, M_RDATA
    );

    modport slave (
        output INST_RDEN, INST_RIADDR,
        input  INST_ROADDR, INST_RVALID, INST_RDATA,
        output DATA_RDEN, DATA_RIADDR, DATA_WREN, DATA_WSTRB, DATA_WADDR, DATA_WDATA,
        input  DATA_ROADDR, DATA_RVALID, DATA_RDATA,
        input  MEM_WAIT, BUS_ERR,
        input  M_REQ, M_WE, M_ADDR, M_WSTRB, M_WDATA,
        output M_READY, M_RVALID, M_RDATA
    );

endinterface

// File: rtl/mem_arb_timeout.sv
// Read-response watchdog: counts cycles spent waiting and flags the last allowed one.
module mem_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_reg;

    // cnt_reg holds the number of completed wait cycles, so the wait cycle
    // numbered TIMEOUT_CYCLES is the one that expires.
    always_ff @(posedge clk) begin
        if (!rst_n || clear || start) begin
            cnt_reg <= '0;
        end else if (run && (cnt_reg != LAST)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && run && (cnt_reg == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises captured store/load/fetch requests onto one downstream port,
// one transaction at a time, data before instructions.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.master bus
);
    state_t            state_reg, state_next;
    logic              wr_reg, drd_reg, ird_reg;
    logic              wr_next, drd_next, ird_next;
    logic [ADDR_W-1:0] waddr_reg, draddr_reg, iraddr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [STRB_W-1:0] wstrb_reg;
    logic              mem_wait_reg;
    logic              inst_rvalid_reg, data_rvalid_reg, bus_err_reg;
    logic [ADDR_W-1:0] inst_roaddr_reg, data_roaddr_reg;
    logic [DATA_W-1:0] inst_rdata_reg, data_rdata_reg;

    op_t  op_sel;
    logic wr_cap, capture;
    logic rd_start, rd_run, rd_expired;
    logic resp_hit, tmo_hit, rd_done;

    assign op_sel   = pick_op(wr_reg, drd_reg);
    assign wr_cap   = bus.DATA_WREN && (bus.DATA_WSTRB != '0);
    assign capture  = (state_reg == IDLE) && (wr_cap || bus.DATA_RDEN || bus.INST_RDEN);
    assign rd_start = (state_reg == ISSUE) && bus.M_READY && (op_sel != OP_WR);
    assign rd_run   = (state_reg == WAIT_RESP);
    assign resp_hit = rd_run && bus.M_RVALID;
    // A response in the expiry cycle still counts as a normal completion.
    assign tmo_hit  = rd_expired && !bus.M_RVALID;
    assign rd_done  = resp_hit || tmo_hit;

    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK),
        .rst_n  (RST),
        .start  (rd_start),
        .run    (rd_run),
        .clear  (state_reg == IDLE),
        .expired(rd_expired)
    );

    always_comb begin
        state_next  = state_reg;
        wr_next     = wr_reg;
        drd_next    = drd_reg;
        ird_next    = ird_reg;
        bus.M_REQ   = 1'b0;
        bus.M_WE    = 1'b0;
        bus.M_ADDR  = '0;
        bus.M_WSTRB = '0;
        bus.M_WDATA = '0;
        case (state_reg)
            IDLE: begin
                if (capture) begin
                    wr_next    = wr_cap;
                    drd_next   = bus.DATA_RDEN;
                    ird_next   = bus.INST_RDEN;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus.M_REQ = 1'b1;
                case (op_sel)
                    OP_WR: begin
                        bus.M_WE    = 1'b1;
                        bus.M_ADDR  = waddr_reg;
                        bus.M_WSTRB = wstrb_reg;
                        bus.M_WDATA = wdata_reg;
                    end
                    OP_DRD: begin
                        bus.M_ADDR  = draddr_reg;
                        bus.M_WSTRB = STRB_ALL;
                    end
                    default: begin
                        bus.M_ADDR  = iraddr_reg;
                        bus.M_WSTRB = STRB_ALL;
                    end
                endcase
                if (bus.M_READY) begin
                    if (op_sel == OP_WR) begin
                        wr_next    = 1'b0;
                        state_next = (drd_reg || ird_reg) ? ISSUE : IDLE;
                    end else begin
                        state_next = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (rd_done) begin
                    if (op_sel == OP_DRD) begin
                        drd_next   = 1'b0;
                        state_next = ird_reg ? ISSUE : IDLE;
                    end else begin
                        ird_next   = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg    <= IDLE;
            wr_reg       <= 1'b0;
            drd_reg      <= 1'b0;
            ird_reg      <= 1'b0;
            mem_wait_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_reg       <= wr_next;
            drd_reg      <= drd_next;
            ird_reg      <= ird_next;
            mem_wait_reg <= (state_next != IDLE);
        end
    end

    always_ff @(posedge CLK) begin
        if (capture) begin
            waddr_reg  <= bus.DATA_WADDR;
            wdata_reg  <= bus.DATA_WDATA;
            wstrb_reg  <= bus.DATA_WSTRB;
            draddr_reg <= bus.DATA_RIADDR;
            iraddr_reg <= bus.INST_RIADDR;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            inst_rvalid_reg <= 1'b0;
            inst_roaddr_reg <= '0;
            inst_rdata_reg  <= '0;
            data_rvalid_reg <= 1'b0;
            data_roaddr_reg <= '0;
            data_rdata_reg  <= '0;
            bus_err_reg     <= 1'b0;
        end else begin
            inst_rvalid_reg <= 1'b0;
            data_rvalid_reg <= 1'b0;
            if (rd_done && (op_sel == OP_DRD)) begin
                data_rvalid_reg <= 1'b1;
                data_roaddr_reg <= draddr_reg;
                data_rdata_reg  <= resp_hit ? bus.M_RDATA : '0;
            end
            if (rd_done && (op_sel == OP_IRD)) begin
                inst_rvalid_reg <= 1'b1;
                inst_roaddr_reg <= iraddr_reg;
                inst_rdata_reg  <= resp_hit ? bus.M_RDATA : '0;
            end
            if (tmo_hit) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    assign bus.MEM_WAIT    = mem_wait_reg;
    assign bus.BUS_ERR     = bus_err_reg;
    assign bus.INST_RVALID = inst_rvalid_reg;
    assign bus.INST_ROADDR = inst_roaddr_reg;
    assign bus.INST_RDATA  = inst_rdata_reg;
    assign bus.DATA_RVALID = data_rvalid_reg;
    assign bus.DATA_ROADDR = data_roaddr_reg;
    assign bus.DATA_RDATA  = data_rdata_reg;

endmodule
